lr35902_int_ctrl: RTL and testbench

//   Interrupt controller for the LR35902 core: collects single-cycle request

---
 rtl/lr35902_pkg.sv | 29 ++
 rtl/lr35902_int_ctrl_if.sv | 28 ++
 rtl/lr35902_int_prio.sv | 25 ++
 rtl/lr35902_int_ctrl.sv | 101 ++++++++++
 tb/tb_lr35902_int_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/lr35902_pkg.sv
// Shared constants and types for the LR35902 interrupt controller.
package lr35902_pkg;

  // Source count and indices; index 0 has the highest priority.
  localparam int unsigned INT_NUM_SRC = 5;
  localparam int unsigned INT_VBLANK  = 0;
  localparam int unsigned INT_STAT    = 1;
  localparam int unsigned INT_TIMER   = 2;
  localparam int unsigned INT_SERIAL  = 3;
  localparam int unsigned INT_JOYPAD  = 4;

  // Restart vector of source 0; source i lands at base + 8*i.
  localparam logic [7:0] INT_VEC_BASE = 8'h40;

  // Register select: 0xFF0F (IF) and 0xFFFF (IE).
  localparam logic ADR_IF = 1'b0;
  localparam logic ADR_IE = 1'b1;

  typedef enum logic [0:0] {
    StIdle,
    StPend
  } int_state_e;

  // Restart vector for a given source index.
  function automatic logic [7:0] int_vector(input logic [7:0] base, input logic [2:0] idx);
    return base + {2'b00, idx, 3'b000};
  endfunction

endpackage

// File: rtl/lr35902_int_ctrl_if.sv
// Register bus, request lines and CPU dispatch handshake of the interrupt controller.
interface lr35902_int_ctrl_if #(
  parameter int unsigned NUM_SRC = 5
);
  logic [7:0]         din;
  logic [7:0]         dout;
  logic               adr;
  logic               read;
  logic               write;
  logic [NUM_SRC-1:0] irq_in;
  logic               ime;
  logic               int_ack;
  logic               int_req;
  logic [7:0]         int_vec;
  logic               wake;

  // CPU / peripheral side.
  modport master (
    output din, adr, read, write, irq_in, ime, int_ack,
    input  dout, int_req, int_vec, wake
  );

  // Controller side.
  modport slave (
    input  din, adr, read, write, irq_in, ime, int_ack,
    output dout, int_req, int_vec, wake
  );
endinterface

// File: rtl/lr35902_int_prio.sv
// Fixed-priority encoder: lowest set index wins.
module lr35902_int_prio #(
  parameter int unsigned NUM_SRC = 5
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [NUM_SRC-1:0] grant,
  output logic [2:0]         index
);

  // Scan from the top down so the lowest set bit is the last one to overwrite.
  always_comb begin
    valid = |req;
    grant = '0;
    index = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        index    = 3'(i);
      end
    end
  end

endmodule

// File: rtl/lr35902_int_ctrl.sv
// LR35902 interrupt controller: IF/IE registers, fixed-priority dispatch FSM,
// restart vector generation and HALT/STOP wake.
module lr35902_int_ctrl
  import lr35902_pkg::*;
#(
  parameter int unsigned NUM_SRC  = INT_NUM_SRC,
  parameter logic [7:0]  VEC_BASE = INT_VEC_BASE
) (
  input logic               clk,
  input logic               reset,
  lr35902_int_ctrl_if.slave bus
);

  logic [NUM_SRC-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic [7:0]         dout_q, dout_d;
  int_state_e         state_q, state_d;

  logic [NUM_SRC-1:0] pending;
  logic               pend_valid;
  logic [NUM_SRC-1:0] pend_grant;
  logic [2:0]         pend_idx;
  logic [NUM_SRC-1:0] ack_clr;
  logic               int_req;
  logic [7:0]         int_vec;
  logic [7:0]         if_rd;

  assign pending = if_q & ie_q[NUM_SRC-1:0];

  lr35902_int_prio #(
    .NUM_SRC(NUM_SRC)
  ) u_prio (
    .req  (pending),
    .valid(pend_valid),
    .grant(pend_grant),
    .index(pend_idx)
  );

  // Dispatch FSM: request while pending, vector tracks the live winner.
  always_comb begin
    state_d = state_q;
    int_req = 1'b0;
    int_vec = 8'h00;
    ack_clr = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.ime && pend_valid) state_d = StPend;
      end
      StPend: begin
        int_req = 1'b1;
        if (pend_valid) int_vec = int_vector(VEC_BASE, pend_idx);
        // Ack takes precedence over ime dropping; a cancelled dispatch clears nothing.
        if (bus.int_ack) begin
          ack_clr = pend_grant;
          state_d = StIdle;
        end else if (!bus.ime) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Register next state: CPU write, then ack clear, then pulses on top.
  always_comb begin
    if_d = if_q;
    ie_d = ie_q;
    if (bus.write && bus.adr == ADR_IF) if_d = bus.din[NUM_SRC-1:0];
    if (bus.write && bus.adr == ADR_IE) ie_d = bus.din;
    if_d = (if_d & ~ack_clr) | bus.irq_in;
  end

  // Read mux; unused IF bits read as ones.
  always_comb begin
    if_rd                = '1;
    if_rd[NUM_SRC-1:0]   = if_q;
    dout_d               = dout_q;
    if (bus.read) dout_d = (bus.adr == ADR_IE) ? ie_q : if_rd;
  end

  // State and register storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_q    <= '0;
      ie_q    <= 8'h00;
      dout_q  <= 8'h00;
      state_q <= StIdle;
    end else begin
      if_q    <= if_d;
      ie_q    <= ie_d;
      dout_q  <= dout_d;
      state_q <= state_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.int_req = int_req;
  assign bus.int_vec = int_vec;
  assign bus.wake    = |pending;

endmodule

// File: tb/tb_lr35902_int_ctrl.sv
// Directed self-checking bench for lr35902_int_ctrl with an expectation queue.
module tb_lr35902_int_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

  lr35902_int_ctrl_if bus_if ();

  lr35902_int_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_v(input string tag, input logic [7:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check(input logic [7:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: got %h want none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s: got %h want %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] exp, input logic [7:0] obs);
    expect_v(tag, exp);
    check(obs);
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    bus_if.adr   = a;
    bus_if.din   = d;
    bus_if.write = 1'b1;
    tick();
    bus_if.write = 1'b0;
  endtask

  task automatic rd(input logic a, input string tag, input logic [7:0] exp);
    expect_v(tag, exp);
    bus_if.adr  = a;
    bus_if.read = 1'b1;
    tick();
    bus_if.read = 1'b0;
    check(bus_if.dout);
  endtask

  task automatic pulse(input logic [4:0] m);
    bus_if.irq_in = m;
    tick();
    bus_if.irq_in = '0;
  endtask

  task automatic ack();
    bus_if.int_ack = 1'b1;
    tick();
    bus_if.int_ack = 1'b0;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b1;
    bus_if.din     = 8'h00;
    bus_if.adr     = 1'b0;
    bus_if.read    = 1'b0;
    bus_if.write   = 1'b0;
    bus_if.irq_in  = '0;
    bus_if.ime     = 1'b0;
    bus_if.int_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 1: reset while a dispatch is pending
    wr(1'b1, 8'h1F);
    bus_if.ime = 1'b1;
    pulse(5'b00001);
    tick();
    chk("t1_req_pend", 8'h01, {7'b0, bus_if.int_req});
    chk("t1_vec_pend", 8'h40, bus_if.int_vec);
    reset = 1'b1;
    #1;
    chk("t1_req_rst", 8'h00, {7'b0, bus_if.int_req});
    chk("t1_vec_rst", 8'h00, bus_if.int_vec);
    chk("t1_wake_rst", 8'h00, {7'b0, bus_if.wake});
    chk("t1_dout_rst", 8'h00, bus_if.dout);
    tick();
    reset      = 1'b0;
    bus_if.ime = 1'b0;
    rd(1'b0, "t1_if_rd", 8'hE0);
    rd(1'b1, "t1_ie_rd", 8'h00);

    // 2: SERIAL dispatch with two-cycle latency
    wr(1'b1, 8'h1F);
    bus_if.ime = 1'b1;
    pulse(5'b01000);
    chk("t2_wake_n1", 8'h01, {7'b0, bus_if.wake});
    chk("t2_req_n1", 8'h00, {7'b0, bus_if.int_req});
    tick();
    chk("t2_req_n2", 8'h01, {7'b0, bus_if.int_req});
    chk("t2_vec", 8'h58, bus_if.int_vec);
    ack();
    chk("t2_req_after_ack", 8'h00, {7'b0, bus_if.int_req});
    rd(1'b0, "t2_if_rd", 8'hE0);

    // 3: simultaneous VBLANK and TIMER, VBLANK first
    pulse(5'b00101);
    tick();
    chk("t3_vec_first", 8'h40, bus_if.int_vec);
    ack();
    rd(1'b0, "t3_if_rd", 8'hE4);
    chk("t3_req_again", 8'h01, {7'b0, bus_if.int_req});
    chk("t3_vec_second", 8'h50, bus_if.int_vec);

    // 4: IE cleared during PEND cancels the dispatch
    wr(1'b1, 8'h00);
    chk("t4_req_cancel", 8'h01, {7'b0, bus_if.int_req});
    chk("t4_vec_cancel", 8'h00, bus_if.int_vec);
    ack();
    chk("t4_req_after_ack", 8'h00, {7'b0, bus_if.int_req});
    rd(1'b0, "t4_if_rd", 8'hE4);

    // 5: wake is independent of ime
    bus_if.ime = 1'b0;
    wr(1'b1, 8'h01);
    pulse(5'b00001);
    chk("t5_wake", 8'h01, {7'b0, bus_if.wake});
    chk("t5_req_ime0", 8'h00, {7'b0, bus_if.int_req});
    tick();
    chk("t5_req_ime0_b", 8'h00, {7'b0, bus_if.int_req});
    bus_if.ime = 1'b1;
    tick();
    chk("t5_req_ime1", 8'h01, {7'b0, bus_if.int_req});
    chk("t5_vec", 8'h40, bus_if.int_vec);
    ack();
    rd(1'b0, "t5_if_rd", 8'hE4);

    // 6: same-edge priority of pulse over write and over ack
    wr(1'b1, 8'h10);
    bus_if.adr    = 1'b0;
    bus_if.din    = 8'h00;
    bus_if.write  = 1'b1;
    bus_if.irq_in = 5'b10000;
    tick();
    bus_if.write  = 1'b0;
    bus_if.irq_in = '0;
    rd(1'b0, "t6_if_wr_vs_pulse", 8'hF0);
    chk("t6_req", 8'h01, {7'b0, bus_if.int_req});
    chk("t6_vec", 8'h60, bus_if.int_vec);
    bus_if.int_ack = 1'b1;
    bus_if.irq_in  = 5'b10000;
    tick();
    bus_if.int_ack = 1'b0;
    bus_if.irq_in  = '0;
    chk("t6_req_after_ack", 8'h00, {7'b0, bus_if.int_req});
    rd(1'b0, "t6_if_ack_vs_pulse", 8'hF0);
    chk("t6_req_again", 8'h01, {7'b0, bus_if.int_req});
    chk("t6_vec_again", 8'h60, bus_if.int_vec);

    // ime drop in PEND returns to IDLE without touching IF; ack in IDLE ignored
    bus_if.ime = 1'b0;
    tick();
    chk("t6_req_ime_drop", 8'h00, {7'b0, bus_if.int_req});
    ack();
    rd(1'b0, "t6_if_idle_ack", 8'hF0);
    rd(1'b1, "t6_ie_rd", 8'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
